// File: rtl/beta_irq_ctrl.sv
// rtl/beta_irq_ctrl.sv - edge-triggered, masked, fixed-priority interrupt controller
//
// Purpose: latches rising edges of irq_in into a pending register. When a pending,
// unmasked source exists, the controller raises irq for the lowest-index source.
// It then waits for the datapath to acknowledge (irq_ack). It stays in service
// until the handler returns (irq_ret).
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   irq_in[NSRC]      - raw interrupt lines (already synchronous to clk)
//   mask_we, mask_wd  - mask register load enable / value (1 = enabled)
//   irq               - interrupt request, high only while a request is outstanding
//   irq_ack, irq_ret  - datapath took the interrupt / handler returned
//   vec               - handler address for src_id
//   src_id            - requesting or in-service source index
//   pending, mask     - pending and mask registers
module beta_irq_ctrl #(
    parameter int unsigned  NSRC       = 4,
    parameter logic [31:0]  VEC_BASE   = 32'h0000_0008,
    parameter int unsigned  VEC_STRIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wd,
    output logic            irq,
    input  logic            irq_ack,
    input  logic            irq_ret,
    output logic [31:0]     vec,
    output logic [2:0]      src_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q;
    logic [2:0]      src_q, src_d;

    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] src_onehot;
    logic [NSRC-1:0] pend_clr;
    logic [2:0]      winner;
    logic            src_enabled;

    assign edge_det = irq_in & ~prev_q;
    assign eligible = pending_q & mask_q;

    // Lowest index wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        src_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_onehot[i] = (src_q == 3'(i));
        end
    end

    assign src_enabled = |(src_onehot & mask_q);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        pend_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_REQ;
                    src_d   = winner;
                end
            end
            ST_REQ: begin
                // An acknowledge beats a mask clear in the same cycle.
                if (irq_ack) begin
                    state_d  = ST_SERVICE;
                    pend_clr = src_onehot;
                end else if (!src_enabled) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (irq_ret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new edge on the source being acknowledged keeps it pending.
    assign pending_d = (pending_q & ~pend_clr) | edge_det;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            // Sampling the live lines means a line held high through reset shows no edge.
            prev_q    <= irq_in;
            pending_q <= '0;
            mask_q    <= '0;
            src_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= irq_in;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wd;
            end
            src_q     <= src_d;
        end
    end

    assign irq     = (state_q == ST_REQ);
    assign src_id  = src_q;
    assign vec     = VEC_BASE + VEC_STRIDE * 32'(src_q);
    assign pending = pending_q;
    assign mask    = mask_q;

endmodule
